mux_select_sequencer: RTL



---
 rtl/mux_select_sequencer_pkg.sv | 39 +++
 rtl/mux_select_sequencer_if.sv | 31 +++
 rtl/mux_select_sequencer_rr_pick4.sv | 21 ++
 rtl/mux_select_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mux_select_sequencer_pkg.sv
// Shared definitions for the mux select sequencer: channel indices,
// FSM state encoding and the rotating-priority winner search.
package mux_pkg;

    localparam int NUM_CH = 4;

    // Channel index as driven onto {S0,S1}; matches the downstream mux decode.
    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

    // Scans req starting just after last and wrapping round, so last itself
    // is the final candidate. Returns {found, idx}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [2:0] result;
        logic [1:0] cand;
        result = 3'b000;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = last + 2'(i);
            if (!result[2] && req[cand]) begin
                result = {1'b1, cand};
            end
        end
        return result;
    endfunction

    // One-hot form of a channel index, same bit order as the request vector.
    function automatic logic [3:0] ch_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Request/select bundle between the requesters, the sequencer and the 4:1 mux.
// The master side is the sequencer (consumes EN/REQ, drives the selects);
// the slave side is whatever supplies requests and watches the grant.
interface mux_select_sequencer_if;

    logic       EN;
    logic [3:0] REQ;
    logic       S0;
    logic       S1;
    logic       VALID;
    logic [3:0] GRANT;

    modport master (
        input  EN,
        input  REQ,
        output S0,
        output S1,
        output VALID,
        output GRANT
    );

    modport slave (
        output EN,
        output REQ,
        input  S0,
        input  S1,
        input  VALID,
        input  GRANT
    );

endinterface

// File: rtl/mux_select_sequencer_rr_pick4.sv
// Combinational 4-way rotating priority encoder. The search starts one past
// the last granted channel so every requester eventually gets a turn.
import mux_pkg::*;

module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);

    logic [2:0] pick;

    // Winner search is purely combinational; the caller registers the result.
    always_comb begin
        pick  = rr_pick(req, last);
        found = pick[2];
        idx   = pick[1:0];
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// Round-robin select generator for the downstream 4:1 data mux. Grants one
// requesting channel at a time, holds it for DWELL cycles (or until its
// request drops), then rotates. All outputs come straight from flops, so
// there is no combinational path from REQ/EN to the mux selects.
import mux_pkg::*;

module mux_select_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux_select_sequencer_if.master  sel_if
);

    localparam logic [CW-1:0] CNT_RELOAD = CW'(DWELL - 1);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [1:0]    ch;
    logic [1:0]    ch_nxt;
    logic [1:0]    last;
    logic [1:0]    last_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          valid;
    logic          valid_nxt;
    logic [3:0]    grant;
    logic [3:0]    grant_nxt;

    logic          win_found;
    logic [1:0]    win_idx;
    logic          cur_req;
    logic          release_now;

    rr_pick4 u_pick (
        .req   (sel_if.REQ),
        .last  (last),
        .found (win_found),
        .idx   (win_idx)
    );

    // The held channel lets go when its own request drops or its dwell runs out.
    always_comb begin
        cur_req     = sel_if.REQ[ch];
        release_now = !cur_req || (cnt == '0);
    end

    // Next-state and next-output logic. A new winner is always loaded the same
    // way whether it comes from IDLE or from a back-to-back switch in HOLD;
    // in HOLD the search pointer equals the held channel, so the search begins
    // at the channel after it. S0/S1 and LAST are left alone when dropping to
    // IDLE so the mux keeps a stable select and fairness survives a disable.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        last_nxt  = last;
        cnt_nxt   = cnt;
        valid_nxt = valid;
        grant_nxt = grant;

        unique case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                grant_nxt = '0;
                if (sel_if.EN && win_found) begin
                    state_nxt = HOLD;
                    ch_nxt    = win_idx;
                    last_nxt  = win_idx;
                    cnt_nxt   = CNT_RELOAD;
                    valid_nxt = 1'b1;
                    grant_nxt = ch_onehot(win_idx);
                end
            end

            HOLD: begin
                if (!sel_if.EN) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    grant_nxt = '0;
                end else if (release_now) begin
                    if (win_found) begin
                        state_nxt = HOLD;
                        ch_nxt    = win_idx;
                        last_nxt  = win_idx;
                        cnt_nxt   = CNT_RELOAD;
                        valid_nxt = 1'b1;
                        grant_nxt = ch_onehot(win_idx);
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        grant_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                grant_nxt = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset puts LAST on D so
    // the very first search starts at channel A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch    <= CH_A;
            last  <= CH_D;
            cnt   <= '0;
            valid <= 1'b0;
            grant <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            valid <= valid_nxt;
            grant <= grant_nxt;
        end
    end

    // S0 carries the index MSB and S1 the LSB, matching the mux select pins.
    always_comb begin
        sel_if.S0    = ch[1];
        sel_if.S1    = ch[0];
        sel_if.VALID = valid;
        sel_if.GRANT = grant;
    end

endmodule
